// File: rtl/sign_narrow_pkg.sv
// ---------------------------------------------------------------------------
// sign_narrow_pkg
//   Shared constants for the sign_narrow block.
//   - IN_W_DEF / OUT_W_DEF : default input/output word widths
//   - SAT_MAX_DEF / SAT_MIN_DEF : signed saturation limits at OUT_W_DEF
//   - sat_max / sat_min : the same limits for any output width up to 32
// ---------------------------------------------------------------------------
package sign_narrow_pkg;

    localparam int IN_W_DEF  = 16;
    localparam int OUT_W_DEF = 8;

    localparam logic signed [OUT_W_DEF-1:0] SAT_MAX_DEF = 8'sh7F;
    localparam logic signed [OUT_W_DEF-1:0] SAT_MIN_DEF = 8'sh80;

    // Largest positive two's-complement value in w bits, right-aligned.
    function automatic logic [31:0] sat_max(input int w);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Most negative two's-complement value in w bits, right-aligned.
    function automatic logic [31:0] sat_min(input int w);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) begin
            if (i == w - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/sign_narrow_fifo2.sv
// ---------------------------------------------------------------------------
// fifo2
//   Two-entry synchronous FIFO with valid/ready on both sides.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     i_push_vld        : producer offers i_push_data
//     o_push_rdy        : a slot is free (registered state only)
//     i_push_data [W]   : entry to store
//     o_pop_vld         : o_pop_data holds the head entry
//     i_pop_rdy         : consumer takes the head entry
//     o_pop_data  [W]   : head entry; holds the last popped entry when empty
// ---------------------------------------------------------------------------
module fifo2 #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push_vld,
    output logic         o_push_rdy,
    input  logic [W-1:0] i_push_data,
    output logic         o_pop_vld,
    input  logic         i_pop_rdy,
    output logic [W-1:0] o_pop_data
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    logic w_push;
    logic w_pop;

    assign o_push_rdy = (r_count != 2'd2);
    assign o_pop_vld  = (r_count != 2'd0);
    assign w_push     = i_push_vld & o_push_rdy;
    assign w_pop      = o_pop_vld & i_pop_rdy;

    // When empty the read pointer already points at the next write slot, so
    // the previous slot is shown instead; that keeps the last popped entry on
    // the output until a new one arrives.
    assign o_pop_data = (r_count == 2'd0) ? r_mem[~r_rd_ptr] : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sign_narrow.sv
// ---------------------------------------------------------------------------
// sign_narrow
//   Narrows a signed IN_W-bit word to OUT_W bits, either saturating or
//   truncating on overflow, and buffers the result in a 2-entry FIFO.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     in_valid/in_ready   : input handshake (in_ready from FIFO state only)
//     in_data  [IN_W]     : two's-complement value to narrow
//     in_sat              : 1 = saturate on overflow, 0 = truncate
//     out_valid/out_ready : output handshake
//     out_data [OUT_W]    : narrowed value
//     out_ovf             : input was not representable in OUT_W bits
//     clr_cnt             : synchronous clear of ovf_cnt (wins over increment)
//     ovf_cnt  [8]        : saturating count of accepted overflowing items
// ---------------------------------------------------------------------------
module sign_narrow
    import sign_narrow_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    input  logic             clr_cnt,
    output logic [7:0]       ovf_cnt
);

    localparam logic [31:0] SAT_MAX_32 = sat_max(OUT_W);
    localparam logic [31:0] SAT_MIN_32 = sat_min(OUT_W);
    localparam logic signed [OUT_W-1:0] SAT_MAX = SAT_MAX_32[OUT_W-1:0];
    localparam logic signed [OUT_W-1:0] SAT_MIN = SAT_MIN_32[OUT_W-1:0];

    // A value fits in OUT_W signed bits when every bit from the output's sign
    // position up to the input's sign position equals the input sign.
    function automatic logic is_repr(input logic signed [IN_W-1:0] d);
        return d[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){d[IN_W-1]}};
    endfunction

    function automatic logic signed [OUT_W-1:0] narrow(
        input logic signed [IN_W-1:0] d,
        input logic                   sat
    );
        if (!is_repr(d) && sat) begin
            return d[IN_W-1] ? SAT_MIN : SAT_MAX;
        end
        return d[OUT_W-1:0];
    endfunction

    // ---- stage p0: narrowing at acceptance -------------------------------
    logic signed [IN_W-1:0]  w_in_p0;
    logic signed [OUT_W-1:0] w_nar_p0;
    logic                    w_ovf_p0;
    logic                    w_push_p0;
    logic                    w_in_ready;

    assign w_in_p0   = in_data;
    assign w_nar_p0  = narrow(w_in_p0, in_sat);
    assign w_ovf_p0  = ~is_repr(w_in_p0);
    assign w_push_p0 = in_valid & w_in_ready;
    assign in_ready  = w_in_ready;

    // ---- stage p1: buffered results --------------------------------------
    logic [OUT_W:0] w_pop_data_p1;

    fifo2 #(
        .W (OUT_W + 1)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push_vld  (in_valid),
        .o_push_rdy  (w_in_ready),
        .i_push_data ({w_ovf_p0, w_nar_p0}),
        .o_pop_vld   (out_valid),
        .i_pop_rdy   (out_ready),
        .o_pop_data  (w_pop_data_p1)
    );

    assign out_data = w_pop_data_p1[OUT_W-1:0];
    assign out_ovf  = w_pop_data_p1[OUT_W];

    // Overflow counter: sticks at 255, clear beats a same-cycle increment.
    logic [7:0] r_ovf_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            r_ovf_cnt <= 8'd0;
        end else if (w_push_p0 && w_ovf_p0 && (r_ovf_cnt != 8'hFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    assign ovf_cnt = r_ovf_cnt;

endmodule

// File: tb/tb_sign_narrow.sv
module tb_sign_narrow;

    localparam int IN_W  = 16;
    localparam int OUT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_data = '0;
    logic             in_sat = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;
    logic             clr_cnt = 1'b0;
    logic [7:0]       ovf_cnt;

    always #5 clk = ~clk;

    sign_narrow #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sat    (in_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .clr_cnt   (clr_cnt),
        .ovf_cnt   (ovf_cnt)
    );

    typedef struct {
        logic [OUT_W-1:0] d;
        logic             ovf;
    } exp_t;

    exp_t q[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   model_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: decide representability from the integer value range.
    function automatic exp_t ref_model(input logic [IN_W-1:0] din, input logic sat);
        exp_t e;
        int   v;
        int   lo;
        int   hi;
        v  = int'($signed(din));
        lo = -(1 << (OUT_W - 1));
        hi = (1 << (OUT_W - 1)) - 1;
        e.ovf = (v < lo) || (v > hi);
        if (e.ovf && sat) e.d = (v < 0) ? lo[OUT_W-1:0] : hi[OUT_W-1:0];
        else              e.d = din[OUT_W-1:0];
        return e;
    endfunction

    // One clock of stimulus; returns whether the item was accepted.
    task automatic cycle(input logic v, input logic [IN_W-1:0] d, input logic s,
                         input logic ordy, input logic clr, output logic acc);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_sat    = s;
        out_ready = ordy;
        clr_cnt   = clr;
        #1;
        check("ovf_cnt", 32'(ovf_cnt), 32'(model_cnt));
        check("in_ready", 32'(in_ready), 32'(q.size() < 2));
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        acc = v && in_ready;
        e = ref_model(d, s);
        if (acc) q.push_back(e);
        if (clr) model_cnt = 0;
        else if (acc && e.ovf && model_cnt < 255) model_cnt++;
    endtask

    task automatic idle(input logic ordy);
        logic a;
        cycle(1'b0, '0, 1'b0, ordy, 1'b0, a);
    endtask

    task automatic push(input logic [IN_W-1:0] d, input logic s, input logic ordy);
        logic a;
        cycle(1'b1, d, s, ordy, 1'b0, a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h4000;
        in_sat    = 1'b1;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        q.delete();
        model_cnt = 0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks that
    // a stalled item stays put.
    logic             have_hold = 1'b0;
    logic [OUT_W:0]   hold_val  = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid) begin
                if (have_hold) check("hold_stable", 32'({out_ovf, out_data}), 32'(hold_val));
                if (out_ready) begin
                    have_hold = 1'b0;
                    if (q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_item: got %0h expected none", out_data);
                    end else begin
                        e = q.pop_front();
                        check("out_data", 32'(out_data), 32'(e.d));
                        check("out_ovf", 32'(out_ovf), 32'(e.ovf));
                    end
                end else begin
                    have_hold = 1'b1;
                    hold_val  = {out_ovf, out_data};
                end
            end else begin
                have_hold = 1'b0;
            end
        end
    end

    initial begin
        logic acc;
        logic [IN_W-1:0] d;
        int   n;

        // power-on reset
        repeat (2) @(negedge clk);
        do_reset();

        // basic in-range value
        push(16'h000F, 1'b1, 1'b1);
        idle(1'b1);
        check("first_cnt", 32'(ovf_cnt), 32'd0);

        // negative values that fit
        push(16'hFF80, 1'b0, 1'b1);
        push(16'hFFFF, 1'b1, 1'b1);
        idle(1'b1);

        // overflow in both saturation modes
        push(16'h0100, 1'b1, 1'b1);
        push(16'h8000, 1'b1, 1'b1);
        push(16'h0180, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        check("cnt_three", 32'(ovf_cnt), 32'd3);

        // back-pressure: third item stalls until a slot frees
        push(16'h0001, 1'b0, 1'b0);
        push(16'h0002, 1'b0, 1'b0);
        cycle(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, acc);
        check("stall_third", 32'(acc), 32'd0);
        n = 0;
        acc = 1'b0;
        while (!acc && n < 10) begin
            cycle(1'b1, 16'h0003, 1'b0, 1'b1, 1'b0, acc);
            n++;
        end
        check("third_accepted", 32'(acc), 32'd1);
        repeat (3) idle(1'b1);

        // counter saturation, then clear beating a simultaneous overflow
        do_reset();
        repeat (300) push(16'h4000 | 16'($urandom_range(0, 255)), 1'($urandom), 1'b1);
        idle(1'b1);
        check("cnt_sat", 32'(ovf_cnt), 32'd255);
        cycle(1'b1, 16'h7000, 1'b1, 1'b1, 1'b1, acc);
        idle(1'b1);
        check("cnt_clr", 32'(ovf_cnt), 32'd0);
        repeat (2) idle(1'b1);

        // reset with two items buffered
        push(16'h0011, 1'b0, 1'b0);
        push(16'h2022, 1'b1, 1'b0);
        check("two_buffered", 32'(q.size()), 32'd2);
        do_reset();
        repeat (3) idle(1'b1);

        // every sign-extended OUT_W value must round-trip without overflow
        for (int i = 0; i < 256; i++) begin
            d = {{(IN_W-OUT_W){i[OUT_W-1]}}, i[OUT_W-1:0]};
            push(d, 1'($urandom), 1'b1);
        end
        idle(1'b1);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                d = 16'($urandom);
            end else begin
                d = 16'($signed(8'($urandom)));
            end
            cycle(1'($urandom_range(0, 3) != 0), d, 1'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0), acc);
        end

        // drain, bounded
        n = 0;
        while (q.size() != 0 && n < 20) begin
            idle(1'b1);
            n++;
        end
        idle(1'b1);
        check("drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sign_narrow.md
SIGN_NARROW -- requirements
Module: sign_narrow

Interface
REQ-001 Parameter IN_W, default 16, input word width.
REQ-002 Parameter OUT_W, default 8, output word width; OUT_W < IN_W.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port in_valid  input  1  producer presents in_data/in_sat.
REQ-006 Port in_ready  output  1  block accepts an item this cycle.
REQ-007 Port in_data  input  IN_W  two's-complement value to narrow.
REQ-008 Port in_sat  input  1  1 = saturate on overflow, 0 = truncate; sampled with in_data.
REQ-009 Port out_valid  output  1  out_data/out_ovf hold a valid item.
REQ-010 Port out_ready  input  1  consumer accepts the item.
REQ-011 Port out_data  output  OUT_W  narrowed value.
REQ-012 Port out_ovf  output  1  the item's input was not representable in OUT_W signed bits.
REQ-013 Port clr_cnt  input  1  synchronous clear of ovf_cnt.
REQ-014 Port ovf_cnt  output  8  saturating count of accepted overflowing items.

Function
REQ-015 Transfer occurs on a handshake side when valid and ready are both 1 at a rising edge.
REQ-016 Representable iff in_data[IN_W-1:OUT_W-1] are all equal; out_ovf = not representable.
REQ-017 Representable item: out_data = in_data[OUT_W-1:0], regardless of in_sat.
REQ-018 Overflow with in_sat=1: out_data = 0x7F if in_data[IN_W-1]=0, else 0x80 (OUT_W=8 values; generally max/min signed).
REQ-019 Overflow with in_sat=0: out_data = in_data[OUT_W-1:0].
REQ-020 Results are computed at acceptance and stored in a 2-entry FIFO; latency one cycle: item accepted at edge N appears with out_valid=1 after edge N when the FIFO was empty.
REQ-021 in_ready = (FIFO occupancy < 2); registered-state-derived only; never depends combinationally on out_ready.
REQ-022 Simultaneous push and pop at occupancy 1: occupancy stays 1, order preserved.
REQ-023 Full (occupancy 2): in_ready=0; a pop frees one slot, in_ready=1 in the following cycle.
REQ-024 Empty: out_valid=0; out_data/out_ovf hold last driven values (don't-care to consumer).
REQ-025 out_data/out_ovf stay stable while out_valid=1 and out_ready=0.
REQ-026 Strict FIFO order; no item dropped or duplicated.
REQ-027 ovf_cnt increments by 1 per accepted item with overflow, saturates at 255 (no wrap).
REQ-028 clr_cnt=1 sets ovf_cnt to 0 at the edge, taking priority over a simultaneous increment.
REQ-029 Round-trip: narrowing any sign-extended OUT_W value returns it with out_ovf=0.

Reset
REQ-030 rst=1 at an edge: FIFO emptied, out_valid=0, in_ready=1 from next cycle, out_data=0, out_ovf=0, ovf_cnt=0.
REQ-031 Reset mid-operation discards all buffered items; handshakes in the reset cycle have no effect.

Structure
REQ-032 Shared package holds IN_W/OUT_W defaults and signed max/min saturation constants.
REQ-033 One sub-module, fifo2, a parameterised 2-entry synchronous FIFO (width OUT_W+1); narrowing logic lives in sign_narrow.

Verification
REQ-034 in_data=0x000F, in_sat=1, out_ready=1 -> next cycle out_data=0x0F, out_ovf=0, ovf_cnt=0.
REQ-035 in_data=0xFF80 then 0xFFFF -> out_data=0x80 then 0xFF, out_ovf=0 both.
REQ-036 in_data=0x0100 in_sat=1 -> 0x7F,ovf=1; 0x8000 in_sat=1 -> 0x80,ovf=1; 0x0180 in_sat=0 -> 0x80,ovf=1; ovf_cnt=3.
REQ-037 out_ready=0, push 0x0001,0x0002,0x0003 -> third stalled (in_ready=0); release -> 0x01,0x02,0x03 in order.
REQ-038 256+ overflowing items -> ovf_cnt holds 255; clr_cnt with overflowing push same cycle -> ovf_cnt=0.
REQ-039 Two items buffered, assert rst one cycle -> out_valid=0, ovf_cnt=0, in_ready=1 after; no stale item emitted.
